// File: rtl/rr_mux8_arbiter_pkg.sv
// Shared types, constants and the round-robin pick function for the 8-way
// arbiter and its data mux.
package rr_mux8_arbiter_pkg;

   localparam int NUM_REQ = 8;
   localparam int SEL_W   = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arbState_t;

   // First set bit of reqValid, searching circularly from lastGrant+1.
   // The 3-bit index arithmetic wraps 7 -> 0 naturally. With no request
   // pending the result is lastGrant+1; callers only use it when reqValid
   // is non-zero.
   function automatic logic [SEL_W-1:0] nextRrIndex(
      input logic [NUM_REQ-1:0] reqValid,
      input logic [SEL_W-1:0]   lastGrant
   );
      logic [SEL_W-1:0] idx;
      logic [SEL_W-1:0] pick;
      logic             found;
      pick  = lastGrant + SEL_W'(1);
      found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = lastGrant + SEL_W'(k);
         if (!found && reqValid[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/rr_mux8_arbiter_mux.sv
// DATA_W-wide 8:1 data multiplexer steered by the arbiter's registered select.
module mux8_data
   import rr_mux8_arbiter_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [NUM_REQ*DATA_W-1:0] dataIn,
   input  logic [SEL_W-1:0]          selectLine,
   output logic [DATA_W-1:0]         dataOut
);

   logic [DATA_W-1:0] words [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign words[i] = dataIn[i*DATA_W +: DATA_W];
   end

   assign dataOut = words[selectLine];

endmodule

// File: rtl/rr_mux8_arbiter.sv
// Round-robin arbiter: grants one of eight valid/ready producers the shared
// output channel for a burst of up to MAX_BURST accepted beats.
module rr_mux8_arbiter
   import rr_mux8_arbiter_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        reqValid,
   input  logic [NUM_REQ*DATA_W-1:0] reqData,
   output logic [NUM_REQ-1:0]        reqReady,
   output logic                      outValid,
   output logic [DATA_W-1:0]         outData,
   output logic [SEL_W-1:0]          outSrc,
   input  logic                      outReady
);

   localparam logic [8:0] BURST_LIMIT = 9'(MAX_BURST);

   arbState_t        state,     stateNext;
   logic [SEL_W-1:0] sel,       selNext;
   logic [SEL_W-1:0] lastGrant, lastGrantNext;
   logic [7:0]       beatCnt,   beatCntNext;
   logic             selValid;
   logic             lastBeat;

   assign selValid = reqValid[sel];
   assign lastBeat = ({1'b0, beatCnt} + 9'd1) == BURST_LIMIT;
   assign outSrc   = sel;

   mux8_data #(
      .DATA_W(DATA_W)
   ) u_mux (
      .dataIn    (reqData),
      .selectLine(sel),
      .dataOut   (outData)
   );

   // NOTE: every output and next-state signal gets a default first, so no
   // path through the case leaves one unassigned and no latch is inferred.
   always_comb begin
      stateNext     = state;
      selNext       = sel;
      lastGrantNext = lastGrant;
      beatCntNext   = beatCnt;
      outValid      = 1'b0;
      reqReady      = '0;

      case (state)
         IDLE: begin
            if (|reqValid) begin
               stateNext   = GRANT;
               selNext     = nextRrIndex(reqValid, lastGrant);
               beatCntNext = '0;
            end
         end
         GRANT: begin
            outValid = selValid;
            reqReady = outReady ? (NUM_REQ'(1) << sel) : '0;
            if (!selValid) begin
               stateNext     = IDLE;
               lastGrantNext = sel;
            end else if (outReady) begin
               beatCntNext = beatCnt + 8'd1;
               if (lastBeat) begin
                  stateNext     = IDLE;
                  lastGrantNext = sel;
               end
            end
         end
         default: stateNext = IDLE;
      endcase

      // Nothing may be accepted while reset is being applied.
      if (rst) begin
         outValid = 1'b0;
         reqReady = '0;
      end
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         sel       <= '0;
         lastGrant <= SEL_W'(NUM_REQ - 1);
         beatCnt   <= '0;
      end else begin
         state     <= stateNext;
         sel       <= selNext;
         lastGrant <= lastGrantNext;
         beatCnt   <= beatCntNext;
      end
   end

   assert property (@(posedge clk) disable iff (rst) $onehot0(reqReady));

   assert property (@(posedge clk) disable iff (rst)
      (state == GRANT && stateNext == GRANT) |=> $stable(sel));

   assert property (@(posedge clk) disable iff (rst)
      (state == IDLE) |-> (!outValid && reqReady == '0));

endmodule

// File: tb/tb_rr_mux8_arbiter.sv
// Self-checking bench: directed vector table, hand-written corner sequences and
// randomized traffic against a grant-level model, for MAX_BURST=4 and 1.
module tb_rr_mux8_arbiter;

   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [7:0]    reqValid = 8'h00;
   logic [8*DW-1:0] reqData = '0;
   logic          outReady = 1'b0;

   logic [7:0]    reqReadyA, reqReadyB;
   logic          outValidA, outValidB;
   logic [DW-1:0] outDataA,  outDataB;
   logic [2:0]    outSrcA,   outSrcB;

   rr_mux8_arbiter #(.DATA_W(DW), .MAX_BURST(4)) dut (
      .clk(clk), .rst(rst), .reqValid(reqValid), .reqData(reqData),
      .reqReady(reqReadyA), .outValid(outValidA), .outData(outDataA),
      .outSrc(outSrcA), .outReady(outReady)
   );

   rr_mux8_arbiter #(.DATA_W(DW), .MAX_BURST(1)) dutB (
      .clk(clk), .rst(rst), .reqValid(reqValid), .reqData(reqData),
      .reqReady(reqReadyB), .outValid(outValidB), .outData(outDataB),
      .outSrc(outSrcB), .outReady(outReady)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Grant-level model: owner is the granted requester or -1 when idle.
   int mOwner[2] = '{-1, -1};
   int mSel[2]   = '{0, 0};
   int mLast[2]  = '{7, 7};
   int mBeats[2] = '{0, 0};
   int burst[2]  = '{4, 1};

   function automatic int rrPick(input logic [7:0] rv, input int last);
      for (int k = 1; k <= 8; k++)
         if (rv[(last + k) % 8]) return (last + k) % 8;
      return -1;
   endfunction

   task automatic modelCheck();
      for (int m = 0; m < 2; m++) begin
         logic       gr, expV, aV;
         logic [7:0] expRdy, aRdy;
         logic [2:0] aSrc;
         logic [DW-1:0] aData;
         string      tag;
         gr     = mOwner[m] >= 0;
         expV   = gr && reqValid[mSel[m]] && !rst;
         expRdy = (gr && outReady && !rst) ? 8'(1 << mSel[m]) : 8'h00;
         if (m == 0) begin
            aV = outValidA; aRdy = reqReadyA; aSrc = outSrcA; aData = outDataA; tag = "A";
         end else begin
            aV = outValidB; aRdy = reqReadyB; aSrc = outSrcB; aData = outDataB; tag = "B";
         end
         check($sformatf("%s.outValid@%0d", tag, cyc), 64'(aV), 64'(expV));
         check($sformatf("%s.reqReady@%0d", tag, cyc), 64'(aRdy), 64'(expRdy));
         check($sformatf("%s.outSrc@%0d", tag, cyc), 64'(aSrc), 64'(mSel[m]));
         if (gr)
            check($sformatf("%s.outData@%0d", tag, cyc), 64'(aData),
                  64'(reqData[mSel[m]*DW +: DW]));
      end
   endtask

   task automatic modelAdvance();
      for (int m = 0; m < 2; m++) begin
         if (rst) begin
            mOwner[m] = -1; mSel[m] = 0; mLast[m] = 7; mBeats[m] = 0;
         end else if (mOwner[m] < 0) begin
            int p;
            p = rrPick(reqValid, mLast[m]);
            if (p >= 0) begin
               mOwner[m] = p; mSel[m] = p; mBeats[m] = 0;
            end
         end else if (!reqValid[mSel[m]]) begin
            mLast[m] = mSel[m]; mOwner[m] = -1;
         end else if (outReady) begin
            mBeats[m]++;
            if (mBeats[m] == burst[m]) begin
               mLast[m] = mSel[m]; mOwner[m] = -1;
            end
         end
      end
      cyc++;
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled 2
   // units later, well before the next edge.
   task automatic drive(input logic r, input logic [7:0] rv, input logic o);
      rst      = r;
      reqValid = rv;
      outReady = o;
      reqData  = {$urandom, $urandom};
      #2;
      modelCheck();
   endtask

   task automatic tick();
      @(posedge clk);
      modelAdvance();
      #1;
   endtask

   task automatic step(input logic r, input logic [7:0] rv, input logic o);
      drive(r, rv, o);
      tick();
   endtask

   task automatic expectA(input string name, input logic v, input logic [7:0] rdy, input logic [2:0] src);
      check({name, ".outValid"}, 64'(outValidA), 64'(v));
      check({name, ".reqReady"}, 64'(reqReadyA), 64'(rdy));
      check({name, ".outSrc"},   64'(outSrcA),   64'(src));
   endtask

   typedef struct {
      logic       r;
      logic [7:0] rv;
      logic       o;
      logic       v;
      logic [7:0] rdy;
      logic [2:0] src;
   } vec_t;

   vec_t tbl[22];

   initial begin
      int order[$];
      int beatsPer[$];
      logic prevValid;
      int n;

      // Single requester, second burst, wrap-around from lastGrant=6, early drop.
      tbl[0]  = '{1'b1, 8'h01, 1'b1, 1'b0, 8'h00, 3'd0};
      tbl[1]  = '{1'b0, 8'h01, 1'b1, 1'b0, 8'h00, 3'd0};
      for (int i = 2; i <= 5; i++) tbl[i] = '{1'b0, 8'h01, 1'b1, 1'b1, 8'h01, 3'd0};
      tbl[6]  = '{1'b0, 8'h01, 1'b1, 1'b0, 8'h00, 3'd0};
      for (int i = 7; i <= 10; i++) tbl[i] = '{1'b0, 8'h01, 1'b1, 1'b1, 8'h01, 3'd0};
      tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0};
      tbl[12] = '{1'b0, 8'h40, 1'b1, 1'b0, 8'h00, 3'd0};
      for (int i = 13; i <= 16; i++) tbl[i] = '{1'b0, 8'h40, 1'b1, 1'b1, 8'h40, 3'd6};
      tbl[17] = '{1'b0, 8'h41, 1'b1, 1'b0, 8'h00, 3'd6};
      tbl[18] = '{1'b0, 8'h41, 1'b1, 1'b1, 8'h01, 3'd0};
      tbl[19] = '{1'b0, 8'h40, 1'b1, 1'b0, 8'h01, 3'd0};
      tbl[20] = '{1'b0, 8'h40, 1'b1, 1'b0, 8'h00, 3'd0};
      tbl[21] = '{1'b0, 8'h40, 1'b1, 1'b1, 8'h40, 3'd6};

      repeat (2) @(posedge clk);
      #1;

      for (int i = 0; i < 22; i++) begin
         drive(tbl[i].r, tbl[i].rv, tbl[i].o);
         expectA($sformatf("tbl%0d", i), tbl[i].v, tbl[i].rdy, tbl[i].src);
         tick();
      end

      // Fairness: all eight requesting, expect 0..7,0 with four beats each.
      step(1'b1, 8'h00, 1'b0);
      prevValid = 1'b0;
      for (int i = 0; i < 45; i++) begin
         drive(1'b0, 8'hFF, 1'b1);
         if (outValidA && reqReadyA != 8'h00) begin
            if (!prevValid) begin
               order.push_back(int'(outSrcA));
               beatsPer.push_back(0);
            end
            beatsPer[beatsPer.size()-1] += 1;
         end
         prevValid = outValidA;
         tick();
      end
      check("fair.grants", 64'(order.size()), 64'd9);
      for (int i = 0; i < order.size() && i < 9; i++) begin
         check($sformatf("fair.order%0d", i), 64'(order[i]), 64'(i % 8));
         check($sformatf("fair.beats%0d", i), 64'(beatsPer[i]), 64'd4);
      end

      // Backpressure on requester 3 after one accepted beat.
      step(1'b1, 8'h00, 1'b0);
      step(1'b0, 8'h08, 1'b1);
      drive(1'b0, 8'h08, 1'b1);
      expectA("bp.first", 1'b1, 8'h08, 3'd3);
      tick();
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, 8'h08, 1'b0);
         expectA($sformatf("bp.hold%0d", i), 1'b1, 8'h00, 3'd3);
         tick();
      end
      n = 0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 8'h08, 1'b1);
         if (outValidA === 1'b1 && reqReadyA === 8'h08) n++;
         if (i == 3) check("bp.release", 64'(outValidA), 64'd0);
         tick();
      end
      check("bp.remaining", 64'(n), 64'd3);

      // Early drop by requester 5; 7 is next above 5, ahead of 1.
      step(1'b1, 8'h00, 1'b0);
      step(1'b0, 8'h20, 1'b1);
      drive(1'b0, 8'hA2, 1'b1);
      expectA("drop.beat1", 1'b1, 8'h20, 3'd5);
      tick();
      step(1'b0, 8'hA2, 1'b1);
      drive(1'b0, 8'h82, 1'b1);
      check("drop.noValid", 64'(outValidA), 64'd0);
      tick();
      drive(1'b0, 8'h82, 1'b1);
      expectA("drop.idle", 1'b0, 8'h00, 3'd5);
      tick();
      drive(1'b0, 8'h82, 1'b1);
      expectA("drop.next", 1'b1, 8'h80, 3'd7);
      tick();

      // Reset during the second beat of requester 2.
      step(1'b1, 8'h00, 1'b0);
      step(1'b0, 8'h04, 1'b1);
      drive(1'b0, 8'h04, 1'b1);
      expectA("mrst.beat1", 1'b1, 8'h04, 3'd2);
      tick();
      drive(1'b1, 8'h04, 1'b1);
      check("mrst.valid", 64'(outValidA), 64'd0);
      check("mrst.ready", 64'(reqReadyA), 64'd0);
      tick();
      drive(1'b0, 8'h04, 1'b1);
      expectA("mrst.after", 1'b0, 8'h00, 3'd0);
      tick();
      drive(1'b0, 8'h04, 1'b1);
      expectA("mrst.regrant", 1'b1, 8'h04, 3'd2);
      tick();

      // MAX_BURST=1: one beat per grant, then a bubble.
      step(1'b1, 8'h00, 1'b0);
      for (int i = 0; i < 7; i++) begin
         drive(1'b0, 8'hFF, 1'b1);
         check($sformatf("b1.valid%0d", i), 64'(outValidB), 64'(i % 2));
         if (i % 2 == 1)
            check($sformatf("b1.src%0d", i), 64'(outSrcB), 64'((i - 1) / 2));
         tick();
      end

      // Randomized traffic with sticky requests, backpressure and rare resets.
      step(1'b1, 8'h00, 1'b0);
      begin
         logic [7:0] rv;
         rv = 8'h00;
         for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 1) == 0)
               rv = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom | $urandom);
            step(($urandom_range(0, 199) == 0), rv, ($urandom_range(0, 3) != 0));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rr_mux8_arbiter.md
# rr_mux8_arbiter

Round-robin arbiter and sequencer for the 8:1 multiplexer datapath. It shares one output channel among eight requesters and drives the 3-bit select of an 8:1 mux. Each winning requester keeps the select for a burst of up to MAX_BURST accepted beats, and every transfer uses a valid/ready handshake. The block sits between eight producer ports and a single downstream consumer.

## Interface
- DATA_W, 8: width of each requester's data word.
- MAX_BURST, 4: maximum accepted beats per grant (1..255).
- clk  in  1  the single clock; everything is sampled on its rising edge.
- rst  in  1  synchronous, active-high reset.
- reqValid  in  8  per-requester valid; bit i belongs to requester i.
- reqData  in  8*DATA_W  packed data; requester i occupies bits [i*DATA_W +: DATA_W].
- reqReady  out  8  per-requester ready; one-hot or zero.
- outValid  out  1  output word valid.
- outData  out  DATA_W  muxed data word.
- outSrc  out  3  current select line (index of the granted requester).
- outReady  in  1  downstream ready.

## Operation
- Two-state FSM with states IDLE and GRANT.
- Registers: state, sel[2:0] (drives outSrc), lastGrant[2:0], beatCnt[7:0].
- IDLE:
  - outValid=0 and reqReady=0.
  - If reqValid!=0, choose the first set bit, searching circularly from lastGrant+1 (mod 8).
  - Load sel with that index, clear beatCnt, and go to GRANT.
  - If reqValid==0, stay in IDLE.
- GRANT:
  - outData = reqData[sel].
  - outValid = reqValid[sel].
  - reqReady = (1<<sel) when outReady, else 0.
  - A beat is accepted when reqValid[sel] & outReady; each accepted beat increments beatCnt.
- Release from GRANT to IDLE, with lastGrant<=sel, occurs when either:
  - an accepted beat makes beatCnt+1==MAX_BURST, or
  - reqValid[sel]==0 (the requester dropped its request; no beat is accepted that cycle).
- While reqValid[sel]=1 and outReady=0, the grant holds indefinitely with no timeout. sel is stable for the whole grant.
- Non-selected requesters always see reqReady=0. Their reqValid changes during GRANT have no effect.
- The new grant is always computed against the updated lastGrant, so a requester that hits MAX_BURST is served last if all eight are requesting.

## Timing
- Reset values:
  - state=IDLE, sel=0, outSrc=0, lastGrant=7 (requester 0 has first priority), beatCnt=0.
  - outValid=0, reqReady=0, outData=reqData[0].
- Arbitration latency:
  - A request sampled at edge N gives GRANT after edge N.
  - outValid and the first possible acceptance occur in cycle N+1.
- Outputs in GRANT are combinational from registered sel and from reqValid/outReady.
- There is no combinational path from reqValid to outSrc.
- There is one idle bubble cycle between consecutive grants, including re-grant of the same requester.
- Throughput: up to MAX_BURST beats per MAX_BURST+1 cycles.
- Boundary cases:
  - When beatCnt reaches MAX_BURST-1 and a beat is accepted, release occurs at that edge.
  - The circular search wraps past index 7 to 0.
  - MAX_BURST=1 releases after every beat.
- rst asserted mid-burst: at that edge every register returns to its reset value. No beat is accepted in the reset cycle, and reqReady=0 while rst=1.

## Structure
- The shared package holds:
  - NUM_REQ=8 and SEL_W=3;
  - the state typedef (IDLE, GRANT);
  - a function returning the next round-robin index from (reqValid, lastGrant).
- One sub-module is natural: mux8_data, a DATA_W-parameterised 8:1 data mux (dataIn packed, selectLine[2:0], dataOut) that produces outData.
- The FSM, counters and pointer live in the top module.

## Test plan
- Reset, single requester:
  - Stimulus: rst released; reqValid=8'h01, outReady=1, MAX_BURST=4.
  - Response: outSrc=0; 4 beats accepted on consecutive cycles; then 1 IDLE cycle; then requester 0 granted again.
- All requesters, fairness:
  - Stimulus: reqValid=8'hFF, outReady=1.
  - Response: grant order 0,1,2,...,7,0; each grant delivers exactly 4 beats with 1 bubble between grants.
- Wrap-around:
  - Stimulus: lastGrant=6 (after requester 6 served); reqValid=8'h41.
  - Response: next grant is requester 0, not requester 6.
- Backpressure:
  - Stimulus: in GRANT with sel=3, outReady=0 for 10 cycles.
  - Response: outValid=1, reqReady=0, outSrc=3 and beatCnt unchanged throughout; beats resume when outReady=1.
- Early drop:
  - Stimulus: requester 5 drops reqValid after 2 accepted beats.
  - Response: release to IDLE with lastGrant=5; next grant goes to the next pending requester above 5.
- Mid-burst reset:
  - Stimulus: rst=1 for 1 cycle during the second beat of requester 2.
  - Response: outValid=0, reqReady=0, outSrc=0, state IDLE; with reqValid=8'h04 still held, requester 2 is re-granted 1 cycle after rst falls.
